// File: rtl/pipe_launch_ctrl.sv
// Sequential launch/bubble controller for the 5-stage CPU: hazard stalls, branch wait,
// end-of-program drain and done flag. Define LAUNCH_PERF_CNT_EN to add stall/flush counters.
module pipe_launch_ctrl #(
    parameter int unsigned WIDTH               = 32,
    parameter int unsigned INSTRACTION_NUMBERS = 16,
    parameter int unsigned STALL_CYCLES        = 1,
    parameter int unsigned PIPE_DEPTH          = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             is_hazzard,
    input  logic             is_branch,
    input  logic             is_branch_step_4,
    input  logic [WIDTH-1:0] pc_out,
    output logic             is_load_PC,
    output logic             is_load_for_launch_1_2,
    output logic             nop_step_2,
    output logic             nop_step_3,
    output logic             done,
    output logic [2:0]       state
`ifdef LAUNCH_PERF_CNT_EN
    ,
    output logic [15:0]      stall_count,
    output logic [15:0]      flush_count
`endif
);

    localparam logic [2:0] ST_RUN     = 3'd0;
    localparam logic [2:0] ST_STALL   = 3'd1;
    localparam logic [2:0] ST_BR_WAIT = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam int unsigned MAX_CNT = (STALL_CYCLES > PIPE_DEPTH) ? STALL_CYCLES : PIPE_DEPTH;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;

    localparam logic [WIDTH-1:0] PC_LIMIT    = WIDTH'(INSTRACTION_NUMBERS);
    localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_RELOAD = CNT_W'(PIPE_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d                = state_q;
        cnt_d                  = cnt_q;
        is_load_PC             = 1'b0;
        is_load_for_launch_1_2 = 1'b0;
        nop_step_2             = 1'b0;
        nop_step_3             = 1'b0;
        done                   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (is_hazzard) begin
                    nop_step_3 = 1'b1;
                    // The RUN cycle itself is the first bubble.
                    if (STALL_CYCLES > 1) begin
                        state_d = ST_STALL;
                        cnt_d   = STALL_RELOAD;
                    end
                end else if (is_branch) begin
                    nop_step_2 = 1'b1;
                    is_load_PC = is_branch_step_4;
                    if (!is_branch_step_4) begin
                        state_d = ST_BR_WAIT;
                    end
                end else if (pc_out < PC_LIMIT) begin
                    is_load_PC             = 1'b1;
                    is_load_for_launch_1_2 = 1'b1;
                end else begin
                    is_load_for_launch_1_2 = 1'b1;
                    state_d                = ST_DRAIN;
                    cnt_d                  = DRAIN_RELOAD;
                end
            end
            ST_STALL: begin
                nop_step_3 = 1'b1;
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_BR_WAIT: begin
                nop_step_2 = 1'b1;
                is_load_PC = is_branch_step_4;
                if (is_branch_step_4) begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                is_load_for_launch_1_2 = 1'b1;
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;

`ifdef LAUNCH_PERF_CNT_EN
    logic [15:0] stall_q, flush_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (nop_step_3 && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (nop_step_2 && (flush_q != 16'hFFFF)) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;
`endif

endmodule
